// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter sharing one APB master command port between N_REQ
// requesters. One transfer is in flight at a time. The arbiter watches the
// APB bus for completion, returns read data and error status to the granted
// requester with a one-cycle done pulse, and bounds every transfer with a
// timeout counter.
//
// Ports
//   PCLK, PRESET          clock (rising edge), synchronous active-high reset
//   req                   per-requester request level
//   req_write             per-requester direction (1 = write)
//   req_addr/wdata/strb/prot
//                         flattened per-requester command fields; requester i
//                         occupies slice i of each bus
//   gnt                   one-hot grant, zero while idle
//   done                  one-cycle completion pulse on the granted bit
//   rsp_rdata             read data (zero for writes and timeouts), valid with done
//   rsp_err               PSLVERR or timeout, valid with done
//   rsp_timeout           completion was forced by the timeout, valid with done
//   transfer              one-cycle command strobe to the APB master
//   SWRITE/SADDR/SWDATA/SSTRB/SPROT
//                         command fields to the APB master, held from issue
//                         through done
//   PSEL/PENABLE/PREADY/PSLVERR/PRDATA
//                         APB bus observation
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           req_write,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W-1:0]    req_wdata,
   input  logic [N_REQ*DATA_W/8-1:0]  req_strb,
   input  logic [N_REQ*3-1:0]         req_prot,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           done,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   output logic                       rsp_timeout,
   output logic                       transfer,
   output logic                       SWRITE,
   output logic [ADDR_W-1:0]          SADDR,
   output logic [DATA_W-1:0]          SWDATA,
   output logic [DATA_W/8-1:0]        SSTRB,
   output logic [2:0]                 SPROT,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PREADY,
   input  logic                       PSLVERR,
   input  logic [DATA_W-1:0]          PRDATA
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = $clog2(N_REQ);
   localparam int CNT_W  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // -----------------------------------------------------------------------
   // Unpack the flattened requester buses into per-requester arrays
   // -----------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_arr  [N_REQ];
   logic [DATA_W-1:0] wdata_arr [N_REQ];
   logic [STRB_W-1:0] strb_arr  [N_REQ];
   logic [2:0]        prot_arr  [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
         assign strb_arr[gi]  = req_strb[gi*STRB_W +: STRB_W];
         assign prot_arr[gi]  = req_prot[gi*3 +: 3];
      end
   endgenerate

   // -----------------------------------------------------------------------
   // State and datapath flops
   // -----------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q,   ptr_d;     // last winner
   logic [IDX_W-1:0]  win_q,   win_d;     // current winner
   logic [CNT_W-1:0]  cnt_q,   cnt_d;     // WAIT cycle counter
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] strb_q,  strb_d;
   logic [2:0]        prot_q,  prot_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q,   err_d;
   logic              tout_q,  tout_d;

   logic              bus_done;
   logic              cnt_expired;
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  cand_idx;
   logic [N_REQ-1:0]  win_onehot;

   assign bus_done    = PSEL & PENABLE & PREADY;
   assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign win_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;

   // Round-robin search starting one past the last winner, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand_idx  = ptr_q;
      for (int i = 1; i <= N_REQ; i++) begin
         cand_idx = IDX_W'((int'(ptr_q) + i) % N_REQ);
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // -----------------------------------------------------------------------
   // FSM: state register
   // -----------------------------------------------------------------------
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= ST_IDLE;
         ptr_q   <= IDX_W'(N_REQ - 1);
         win_q   <= '0;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         prot_q  <= prot_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tout_q  <= tout_d;
      end
   end

   // -----------------------------------------------------------------------
   // FSM: next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (win_found) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (bus_done || cnt_expired) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // Datapath next values
   // -----------------------------------------------------------------------
   always_comb begin
      ptr_d   = ptr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      prot_d  = prot_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tout_d  = tout_q;
      case (state_q)
         ST_IDLE: begin
            // Capture the winner's command so it stays stable until DONE,
            // even if the requester changes its inputs meanwhile.
            if (win_found) begin
               win_d   = win_idx;
               write_d = req_write[win_idx];
               addr_d  = addr_arr[win_idx];
               wdata_d = wdata_arr[win_idx];
               strb_d  = strb_arr[win_idx];
               prot_d  = prot_arr[win_idx];
            end
         end
         ST_ISSUE: begin
            cnt_d = '0;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Bus completion has priority over a coincident timeout.
            if (bus_done) begin
               rdata_d = write_q ? '0 : PRDATA;
               err_d   = PSLVERR;
               tout_d  = 1'b0;
            end else if (cnt_expired) begin
               rdata_d = '0;
               err_d   = 1'b1;
               tout_d  = 1'b1;
            end
         end
         ST_DONE: begin
            ptr_d = win_q;
         end
         default: ;
      endcase
   end

   // -----------------------------------------------------------------------
   // FSM: outputs
   // -----------------------------------------------------------------------
   always_comb begin
      gnt         = '0;
      done        = '0;
      transfer    = 1'b0;
      rsp_rdata   = '0;
      rsp_err     = 1'b0;
      rsp_timeout = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            gnt      = win_onehot;
            transfer = 1'b1;
         end
         ST_WAIT: begin
            gnt = win_onehot;
         end
         ST_DONE: begin
            gnt         = win_onehot;
            done        = win_onehot;
            rsp_rdata   = rdata_q;
            rsp_err     = err_q;
            rsp_timeout = tout_q;
         end
         default: ;
      endcase
   end

   assign SWRITE = write_q;
   assign SADDR  = addr_q;
   assign SWDATA = wdata_q;
   assign SSTRB  = strb_q;
   assign SPROT  = prot_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Randomised and directed stimulus against a round-robin reference model.
// Expected commands and responses are queued when a request is issued; a
// monitor pops them when the arbiter strobes transfer or done. A small bus
// process plays the APB master/slave, driving PSEL/PENABLE/PREADY after each
// transfer strobe with a queued wait-state profile.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic            PCLK = 1'b0;
   logic            PRESET;
   logic [N-1:0]    req;
   logic [N-1:0]    req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*SW-1:0] req_strb;
   logic [N*3-1:0]  req_prot;
   logic [N-1:0]    gnt, done;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err, rsp_timeout, transfer, SWRITE;
   logic [AW-1:0]   SADDR;
   logic [DW-1:0]   SWDATA;
   logic [SW-1:0]   SSTRB;
   logic [2:0]      SPROT;
   logic            PSEL, PENABLE, PREADY, PSLVERR;
   logic [DW-1:0]   PRDATA;

   apb_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req(req), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout), .transfer(transfer), .SWRITE(SWRITE),
      .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
      .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   // Per-requester command sources
   logic          wr_a    [N];
   logic [AW-1:0] addr_a  [N];
   logic [DW-1:0] wdata_a [N];
   logic [SW-1:0] strb_a  [N];
   logic [2:0]    prot_a  [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_pack
         assign req_write[gi]           = wr_a[gi];
         assign req_addr[gi*AW +: AW]   = addr_a[gi];
         assign req_wdata[gi*DW +: DW]  = wdata_a[gi];
         assign req_strb[gi*SW +: SW]   = strb_a[gi];
         assign req_prot[gi*3 +: 3]     = prot_a[gi];
      end
   endgenerate

   typedef struct {
      int            win;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      logic [2:0]    prot;
      int            cyc;
   } cmd_t;

   typedef struct {
      int            win;
      logic [DW-1:0] rdata;
      logic          err;
      logic          tout;
      int            cyc;
   } rsp_t;

   typedef struct {
      int            waits;
      logic          tout;
      logic [DW-1:0] rdata;
      logic          err;
   } bus_t;

   cmd_t cmd_q [$];
   rsp_t rsp_q [$];
   bus_t bus_q [$];

   int checks = 0;
   int fails  = 0;
   int n_done = 0;
   int n_xfer = 0;
   int model_last = N - 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference arbitration: first set request after the last winner.
   function automatic int pick(input logic [N-1:0] mask);
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (model_last + i) % N;
         if (((mask >> c) & 1) != 0) return c;
      end
      return -1;
   endfunction

   task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input logic [2:0] p);
      wr_a[i]    = wr;
      addr_a[i]  = a;
      wdata_a[i] = d;
      strb_a[i]  = s;
      prot_a[i]  = p;
   endtask

   // Queue the expected command, response and bus profile for winner w whose
   // transfer strobe is expected in cycle xcyc.
   task automatic push_txn(input int w, input int waits, input logic tout,
                           input logic [DW-1:0] prdata, input logic perr,
                           input int xcyc, input logic with_rsp);
      cmd_t c;
      rsp_t r;
      bus_t b;
      c.win = w; c.wr = wr_a[w]; c.addr = addr_a[w]; c.wdata = wdata_a[w];
      c.strb = strb_a[w]; c.prot = prot_a[w]; c.cyc = xcyc;
      cmd_q.push_back(c);
      r.win   = w;
      r.rdata = (tout || wr_a[w]) ? '0 : prdata;
      r.err   = tout | perr;
      r.tout  = tout;
      r.cyc   = xcyc + (tout ? TO + 1 : 3 + waits);
      if (with_rsp) rsp_q.push_back(r);
      b.waits = waits; b.tout = tout; b.rdata = prdata; b.err = perr;
      bus_q.push_back(b);
      model_last = w;
   endtask

   // Called at a negedge while the arbiter is idle.
   task automatic launch(input logic [N-1:0] mask, input int waits, input logic tout,
                         input logic [DW-1:0] prdata, input logic perr);
      push_txn(pick(mask), waits, tout, prdata, perr, cyc + 1, 1'b1);
      req = mask;
   endtask

   task automatic wait_done(input int target);
      for (int k = 0; k < 400 && n_done < target; k++) @(negedge PCLK);
      chk("done_count", 64'(n_done), 64'(target));
   endtask

   task automatic wait_xfer(input int target);
      for (int k = 0; k < 50 && n_xfer < target; k++) @(negedge PCLK);
      chk("xfer_count", 64'(n_xfer), 64'(target));
   endtask

   task automatic finish_txn();
      req = '0;
      @(negedge PCLK);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gnt"},      64'(gnt), 0);
      chk({tag, "_done"},     64'(done), 0);
      chk({tag, "_rdata"},    64'(rsp_rdata), 0);
      chk({tag, "_err"},      64'(rsp_err), 0);
      chk({tag, "_timeout"},  64'(rsp_timeout), 0);
      chk({tag, "_transfer"}, 64'(transfer), 0);
      chk({tag, "_swrite"},   64'(SWRITE), 0);
      chk({tag, "_saddr"},    64'(SADDR), 0);
      chk({tag, "_swdata"},   64'(SWDATA), 0);
      chk({tag, "_sstrb"},    64'(SSTRB), 0);
      chk({tag, "_sprot"},    64'(SPROT), 0);
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   cmd_t cur;
   initial begin
      cur.win = 0; cur.wr = 0; cur.addr = 0; cur.wdata = 0; cur.strb = 0; cur.prot = 0; cur.cyc = 0;
   end

   always @(negedge PCLK) begin
      if (PRESET !== 1'b1) begin
         chk("gnt_onehot", 64'($onehot0(gnt)), 1);
         chk("done_within_gnt", 64'(done & ~gnt), 0);
         if (transfer === 1'b1) begin
            if (cmd_q.size() == 0) begin
               chk("unexpected_transfer", 1, 0);
            end else begin
               cur = cmd_q.pop_front();
               chk("xfer_gnt",    64'(gnt), 64'(4'b0001 << cur.win));
               chk("xfer_cycle",  64'(cyc), 64'(cur.cyc));
               chk("xfer_swrite", 64'(SWRITE), 64'(cur.wr));
               chk("xfer_saddr",  64'(SADDR), 64'(cur.addr));
               chk("xfer_swdata", 64'(SWDATA), 64'(cur.wdata));
               chk("xfer_sstrb",  64'(SSTRB), 64'(cur.strb));
               chk("xfer_sprot",  64'(SPROT), 64'(cur.prot));
               n_xfer++;
            end
         end else if (gnt != '0) begin
            chk("hold_gnt",   64'(gnt), 64'(4'b0001 << cur.win));
            chk("hold_saddr", 64'(SADDR), 64'(cur.addr));
            chk("hold_swdata", 64'(SWDATA), 64'(cur.wdata));
         end
         if (done != '0) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_done", 64'(done), 0);
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("done_vec",    64'(done), 64'(4'b0001 << r.win));
               chk("done_cycle",  64'(cyc), 64'(r.cyc));
               chk("rsp_rdata",   64'(rsp_rdata), 64'(r.rdata));
               chk("rsp_err",     64'(rsp_err), 64'(r.err));
               chk("rsp_timeout", 64'(rsp_timeout), 64'(r.tout));
               $display("txn %0d: requester %0d rdata=0x%08h err=%0d timeout=%0d cycle=%0d",
                        n_done, r.win, rsp_rdata, rsp_err, rsp_timeout, cyc);
            end
            n_done++;
         end
      end
   end

   // ------------------------------------------------------------------
   // APB master + slave stand-in
   // ------------------------------------------------------------------
   initial begin
      PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
      forever begin
         @(negedge PCLK);
         if (transfer === 1'b1) begin
            bus_t b;
            logic ab;
            int   ncyc;
            b.waits = 0; b.tout = 0; b.rdata = '0; b.err = 0;
            if (bus_q.size() == 0) chk("bus_profile_missing", 1, 0);
            else b = bus_q.pop_front();
            ab   = 1'b0;
            ncyc = b.tout ? TO : b.waits + 2;
            for (int k = 0; k < ncyc && !ab; k++) begin
               @(posedge PCLK);
               if (PRESET) begin
                  ab = 1'b1;
               end else begin
                  #1;
                  PSEL    = 1'b1;
                  PENABLE = (k > 0);
                  PREADY  = (!b.tout && k == ncyc - 1);
                  PRDATA  = PREADY ? b.rdata : DW'($urandom);
                  PSLVERR = PREADY ? b.err : 1'($urandom);
               end
            end
            if (!ab) @(posedge PCLK);
            #1;
            PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int base, nd, nx;
      PRESET = 1'b1;
      req    = '0;
      for (int i = 0; i < N; i++) set_cmd(i, 1'b0, '0, '0, '0, '0);
      repeat (3) @(negedge PCLK);
      check_all_zero("reset");
      PRESET = 1'b0;
      model_last = N - 1;
      @(negedge PCLK);

      // All requesters hold writes continuously: grants 0,1,2,3,0 every 5 cycles.
      for (int i = 0; i < N; i++)
         set_cmd(i, 1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 | 32'(i), 4'hF, 3'(i));
      base = cyc;
      nd   = n_done;
      for (int k = 0; k < 5; k++)
         push_txn(pick(4'hF), 0, 1'b0, '0, 1'b0, base + 1 + 5 * k, 1'b1);
      req = 4'hF;
      wait_done(nd + 5);
      finish_txn();

      // Single read from requester 2, zero-wait slave.
      set_cmd(2, 1'b0, 32'h10, 32'h0, 4'h0, 3'd0);
      nd = n_done;
      launch(4'b0100, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      wait_done(nd + 1);
      finish_txn();

      // Write from requester 1, 3 wait states then PSLVERR.
      set_cmd(1, 1'b1, 32'h44, 32'h1234_5678, 4'h3, 3'd2);
      nd = n_done;
      launch(4'b0010, 3, 1'b0, 32'hCAFE_F00D, 1'b1);
      wait_done(nd + 1);
      finish_txn();

      // Slave never ready: timeout.
      set_cmd(3, 1'b0, 32'h80, 32'h0, 4'h0, 3'd5);
      nd = n_done;
      launch(4'b1000, 0, 1'b1, 32'h5555_AAAA, 1'b0);
      wait_done(nd + 1);
      finish_txn();

      // The arbiter still serves the next request after a timeout.
      set_cmd(0, 1'b0, 32'hC0, 32'h0, 4'h0, 3'd1);
      nd = n_done;
      launch(4'b0001, 1, 1'b0, 32'h0BAD_CAFE, 1'b0);
      wait_done(nd + 1);
      finish_txn();

      // req[1] drops during WAIT; the transfer still completes.
      set_cmd(1, 1'b0, 32'h200, 32'h0, 4'h0, 3'd3);
      nd = n_done;
      nx = n_xfer;
      launch(4'b0010, 2, 1'b0, 32'h7777_1111, 1'b0);
      wait_xfer(nx + 1);
      repeat (2) @(negedge PCLK);
      req[1] = 1'b0;
      wait_done(nd + 1);
      finish_txn();

      // Reset during WAIT: no done; afterwards requester 0 beats requester 3.
      set_cmd(1, 1'b0, 32'h300, 32'h0, 4'h0, 3'd0);
      nx = n_xfer;
      push_txn(pick(4'b0010), 10, 1'b0, 32'h1111_2222, 1'b0, cyc + 1, 1'b0);
      req = 4'b0010;
      wait_xfer(nx + 1);
      repeat (3) @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      check_all_zero("midreset");
      PRESET = 1'b0;
      model_last = N - 1;
      set_cmd(0, 1'b1, 32'h400, 32'hFACE_0000, 4'hF, 3'd7);
      set_cmd(3, 1'b1, 32'h430, 32'hFACE_0003, 4'hF, 3'd6);
      nd = n_done;
      launch(4'b1001, 0, 1'b0, 32'h0, 1'b0);
      wait_done(nd + 1);
      finish_txn();

      // Randomised transactions.
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] mask;
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++)
            set_cmd(i, 1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom), 3'($urandom));
         nd = n_done;
         launch(mask, $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
                DW'($urandom), ($urandom_range(0, 3) == 0));
         wait_done(nd + 1);
         finish_txn();
      end

      repeat (3) @(negedge PCLK);
      chk("cmd_queue_empty", 64'(cmd_q.size()), 0);
      chk("rsp_queue_empty", 64'(rsp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares the single APB master command port (transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT) between N_REQ requesters. It sits in front of APB_Master inside the APB wrapper. It issues one transfer at a time and watches the APB bus for completion. It returns read data, error status and a done pulse to the requester that was granted, and it bounds every transfer with a timeout counter.

## Interface
Parameters:
- N_REQ, 4: number of requesters (2..8)
- ADDR_W, 32: address width
- DATA_W, 32: data width; strobe width is DATA_W/8
- TIMEOUT, 16: maximum cycles allowed in WAIT before forced completion (≥4)

Ports:
- PCLK  in  1  clock; everything is on the rising edge
- PRESET  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester request level
- req_write  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i occupies slice i
- req_wdata  in  N_REQ*DATA_W  flattened write data
- req_strb  in  N_REQ*DATA_W/8  flattened write strobes
- req_prot  in  N_REQ*3  flattened protection bits
- gnt  out  N_REQ  one-hot grant; all zero in IDLE
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  DATA_W  read data; valid while done is asserted
- rsp_err  out  1  PSLVERR or timeout; valid while done is asserted
- rsp_timeout  out  1  set in DONE when completion came from the timeout
- transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT  out  to APB_Master command port
- PSEL, PENABLE, PREADY, PSLVERR  in  1 each  bus observation
- PRDATA  in  DATA_W  bus read data

## Operation
- FSM states and transitions:
  - IDLE: if any req bit is set, pick the winner and go to ISSUE.
  - ISSUE: go to WAIT unconditionally.
  - WAIT: go to DONE on completion or when the timeout fires.
  - DONE: go to IDLE unconditionally.
- Winner selection: round-robin. The search starts at (last_winner+1) mod N_REQ. The pointer resets to N_REQ-1, so requester 0 wins first after reset.
- Winner index and its command slice are registered on the IDLE→ISSUE edge. The command outputs stay stable from ISSUE through DONE.
- gnt[winner] is 1 in ISSUE, WAIT and DONE.
- transfer is 1 only in ISSUE, for exactly one cycle. APB_Master latches the command in that cycle.
- Completion is the first WAIT cycle with PSEL & PENABLE & PREADY = 1. In that cycle PRDATA is captured into rsp_rdata and PSLVERR into rsp_err.
- Reads return PRDATA. Writes return rsp_rdata = 0.
- Timeout: a counter clears on entering WAIT and increments each WAIT cycle. If it reaches TIMEOUT-1 without completion, go to DONE with rsp_err = 1, rsp_timeout = 1 and rsp_rdata = 0.
- DONE: done[winner] = 1 for one cycle. The pointer updates to the winner.
- Requesters must hold req and their command until done. If req drops mid-transaction, the arbiter ignores it and the transaction completes and pulses done normally.
- req bits rising during ISSUE, WAIT or DONE wait for arbitration in the next IDLE.
- Reset values: all outputs 0. State is IDLE, the counter is 0 and the pointer is N_REQ-1.
- Reset mid-operation: the arbiter returns to IDLE within one cycle and does not generate done. Any bus transfer in flight is abandoned.

## Timing
- Cycle 0: req seen in IDLE.
- Cycle 1: ISSUE, with transfer = 1 and gnt valid.
- From cycle 2: WAIT. With a zero-wait-state slave, completion falls in cycle 3 (master SETUP in cycle 2, ACCESS in cycle 3).
- Cycle 4: DONE. Minimum request-to-done latency is 4 cycles.
- After DONE there is one IDLE cycle, so back-to-back transfers start every 5 cycles minimum.
- Each extra PREADY = 0 cycle adds one cycle of latency.
- Timeout path: DONE occurs TIMEOUT cycles after the first WAIT cycle.
- Only one gnt bit is ever set. done is only ever set on the bit equal to gnt.

## Test plan
- Single read, zero-wait-state slave: req[2] with addr 0x10, slave returns 0xDEADBEEF → transfer pulses in cycle 1, SADDR = 0x10, done[2] in cycle 4, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- All four requesters hold req continuously, each doing a write → grants go in order 0, 1, 2, 3, 0. Every transfer uses the correct slice. Grant-to-grant spacing is 5 cycles.
- Slave inserts 3 wait states, then PSLVERR = 1, on a write from requester 1 → done[1] in cycle 7, rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- PREADY is never asserted, TIMEOUT = 16 → DONE 16 cycles after WAIT entry, rsp_err = 1, rsp_timeout = 1. The next request is still arbitrated.
- PRESET asserted during WAIT → all outputs are 0 the next cycle and no done pulse occurs. After release, requester 0 wins first even if requester 3 also requests.
- req[1] drops during WAIT → the transaction still completes and done[1] pulses.
